dev_bus_arbiter: RTL

Shares the single device-bus port of the address bridge between two masters: m0, the CPU data-memory stage, and m1, a secondary bus master such as a loader or debug port. Each access is a single beat with a request/acknowledge handshake. The winning request is latched and driven onto the bridge for exactly one cycle. Read data and exception code come back to the winner through registers. The block sits between the masters and the bridge; the bridge still does address decode, write-enable generation and exception detection.

---
 rtl/dev_bus_arbiter_pkg.sv | 34 +++
 rtl/dev_bus_arbiter_if.sv | 26 ++
 rtl/dev_bus_arbiter_pick.sv | 83 ++++++++
 rtl/dev_bus_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/dev_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// dev_bus_arbiter_pkg
// Shared encodings for the device-bus arbiter and the address bridge:
// memory-access modes, exception codes, arbiter FSM states and master ids.
// No ports; imported by every file of the arbiter.
// ----------------------------------------------------------------------------
package dev_bus_arbiter_pkg;

    localparam int MEM_MODE_LEN  = 3;
    localparam int EXC_CODE_LEN  = 5;
    localparam int ARB_STATE_LEN = 2;

    // Memory-access modes seen by the bridge. Other codes are passed through.
    localparam logic [MEM_MODE_LEN-1:0] MEM_MODE_NONE  = 3'd0;
    localparam logic [MEM_MODE_LEN-1:0] MEM_MODE_READ  = 3'd1;
    localparam logic [MEM_MODE_LEN-1:0] MEM_MODE_WRITE = 3'd2;

    // Exception codes produced by the bridge.
    localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_NONE = 5'd0;
    localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_ADEL = 5'd4;
    localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_ADES = 5'd5;

    typedef enum logic [ARB_STATE_LEN-1:0] {
        ARB_STATE_IDLE = 2'd0,
        ARB_STATE_BUSY = 2'd1,
        ARB_STATE_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        MASTER_M0 = 1'b0,
        MASTER_M1 = 1'b1
    } master_id_t;

endpackage

// File: rtl/dev_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// dev_bus_if
// Single-beat request/acknowledge device-bus port of one master.
//   req    master -> arbiter  access request, held until ack
//   addr   master -> arbiter  byte address
//   mode   master -> arbiter  access mode
//   wdata  master -> arbiter  write data
//   ack    arbiter -> master  one-cycle completion pulse
//   rdata  arbiter -> master  read data, valid while ack
//   exc    arbiter -> master  exception code, valid while ack
// ----------------------------------------------------------------------------
interface dev_bus_if;
    import dev_bus_arbiter_pkg::*;

    logic                    req;
    logic [31:0]             addr;
    logic [MEM_MODE_LEN-1:0] mode;
    logic [31:0]             wdata;
    logic                    ack;
    logic [31:0]             rdata;
    logic [EXC_CODE_LEN-1:0] exc;

    modport master (output req, addr, mode, wdata, input  ack, rdata, exc);
    modport slave  (input  req, addr, mode, wdata, output ack, rdata, exc);

endinterface

// File: rtl/dev_bus_arbiter_pick.sv
// ----------------------------------------------------------------------------
// dev_arb_pick
// Winner selection for dev_bus_arbiter.
// Macro DEV_ARB_RR_EN:
//   undefined - m0 priority; m1 is forced through after STARVE_MAX
//               consecutive lost arbitrations (4-bit starvation counter).
//   defined   - round robin with a 1-bit last-grant pointer (resets to m1,
//               so m0 wins the first tie).
// Ports:
//   clk     in   clock
//   reset   in   synchronous active-high reset
//   req0    in   m0 request
//   req1    in   m1 request
//   decide  in   strobe: an arbitration decision is taken this cycle
//   winner  out  master that wins if decide is high (combinational)
// ----------------------------------------------------------------------------
module dev_arb_pick
    import dev_bus_arbiter_pkg::*;
`ifndef DEV_ARB_RR_EN
#(
    parameter int unsigned STARVE_MAX = 3
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       decide,
    output master_id_t winner
);

`ifdef DEV_ARB_RR_EN

    master_id_t last_grant;

    // NOTE: a combinational block assigns its output on every path (here a
    // single if/else covers all cases), otherwise a latch is inferred.
    always_comb begin
        if (req0 && req1) begin
            winner = (last_grant == MASTER_M0) ? MASTER_M1 : MASTER_M0;
        end else begin
            winner = req0 ? MASTER_M0 : MASTER_M1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= MASTER_M1;
        end else if (decide) begin
            last_grant <= winner;
        end
    end

`else

    logic [3:0] starve_cnt;
    logic       force_m1;

    assign force_m1 = req1 && (starve_cnt == 4'(STARVE_MAX));

    // NOTE: a combinational block assigns its output on every path (here a
    // single conditional covers all cases), otherwise a latch is inferred.
    always_comb begin
        winner = (req0 && !force_m1) ? MASTER_M0 : MASTER_M1;
    end

    // Counts consecutive decisions that m1 loses while it is waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (decide) begin
            if (winner == MASTER_M1 || !req1) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != 4'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

`endif

endmodule

// File: rtl/dev_bus_arbiter.sv
// ----------------------------------------------------------------------------
// dev_bus_arbiter
// Shares the bridge's single device-bus port between m0 (CPU data-memory
// stage) and m1 (loader/debug master). Each access takes IDLE -> BUSY -> RESP:
// the winner is latched in IDLE, driven onto the bridge for one cycle in BUSY,
// and acknowledged with registered rdata/exc in RESP.
// Macro DEV_ARB_RR_EN selects round-robin arbitration (STARVE_MAX removed).
// Ports:
//   clk           in   clock
//   reset         in   synchronous active-high reset
//   m0, m1        dev_bus_if.slave  master ports (req/addr/mode/wdata in,
//                                   ack/rdata/exc out)
//   br_vaddr      out  address to bridge (0 outside BUSY)
//   br_mode       out  mode to bridge (NONE outside BUSY and during reset)
//   br_wdata      out  write data to devices (0 outside BUSY)
//   br_read_data  in   bridge read data (combinational)
//   br_exc        in   bridge exception code (combinational)
// ----------------------------------------------------------------------------
module dev_bus_arbiter
    import dev_bus_arbiter_pkg::*;
`ifndef DEV_ARB_RR_EN
#(
    parameter int unsigned STARVE_MAX = 3
)
`endif
(
    input  logic                    clk,
    input  logic                    reset,
    dev_bus_if.slave                m0,
    dev_bus_if.slave                m1,
    output logic [31:0]             br_vaddr,
    output logic [MEM_MODE_LEN-1:0] br_mode,
    output logic [31:0]             br_wdata,
    input  logic [31:0]             br_read_data,
    input  logic [EXC_CODE_LEN-1:0] br_exc
);

    arb_state_t              state;
    master_id_t              grant_id;
    master_id_t              winner;
    logic                    decide;
    logic [MEM_MODE_LEN-1:0] mode_q;

    assign decide = (state == ARB_STATE_IDLE) && (m0.req || m1.req);

`ifdef DEV_ARB_RR_EN
    dev_arb_pick u_pick (
`else
    dev_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
`endif
        .clk    (clk),
        .reset  (reset),
        .req0   (m0.req),
        .req1   (m1.req),
        .decide (decide),
        .winner (winner)
    );

    // Gated combinationally so a write in flight cannot land on the reset edge.
    assign br_mode = reset ? MEM_MODE_NONE : mode_q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_STATE_IDLE;
            grant_id <= MASTER_M0;
            br_vaddr <= 32'd0;
            mode_q   <= MEM_MODE_NONE;
            br_wdata <= 32'd0;
            m0.ack   <= 1'b0;
            m0.rdata <= 32'd0;
            m0.exc   <= EXC_CODE_NONE;
            m1.ack   <= 1'b0;
            m1.rdata <= 32'd0;
            m1.exc   <= EXC_CODE_NONE;
        end else begin
            m0.ack <= 1'b0;
            m1.ack <= 1'b0;
            case (state)
                ARB_STATE_IDLE: begin
                    if (decide) begin
                        grant_id <= winner;
                        if (winner == MASTER_M0) begin
                            br_vaddr <= m0.addr;
                            mode_q   <= m0.mode;
                            br_wdata <= m0.wdata;
                        end else begin
                            br_vaddr <= m1.addr;
                            mode_q   <= m1.mode;
                            br_wdata <= m1.wdata;
                        end
                        state <= ARB_STATE_BUSY;
                    end
                end
                ARB_STATE_BUSY: begin
                    br_vaddr <= 32'd0;
                    mode_q   <= MEM_MODE_NONE;
                    br_wdata <= 32'd0;
                    // Only the winner's response registers take bridge data.
                    m0.ack   <= (grant_id == MASTER_M0);
                    m1.ack   <= (grant_id == MASTER_M1);
                    m0.rdata <= (grant_id == MASTER_M0) ? br_read_data : 32'd0;
                    m0.exc   <= (grant_id == MASTER_M0) ? br_exc : EXC_CODE_NONE;
                    m1.rdata <= (grant_id == MASTER_M1) ? br_read_data : 32'd0;
                    m1.exc   <= (grant_id == MASTER_M1) ? br_exc : EXC_CODE_NONE;
                    state    <= ARB_STATE_RESP;
                end
                ARB_STATE_RESP: begin
                    m0.rdata <= 32'd0;
                    m0.exc   <= EXC_CODE_NONE;
                    m1.rdata <= 32'd0;
                    m1.exc   <= EXC_CODE_NONE;
                    state    <= ARB_STATE_IDLE;
                end
                default: begin
                    state <= ARB_STATE_IDLE;
                end
            endcase
        end
    end

endmodule
